// File: rtl/bcd_counter_2digit.sv
// Two-digit (00-99) BCD up/down counter with prescaler, synchronous clear and
// parallel load. Outputs are fully registered; tc flags a 99->00 / 00->99 wrap.
module bcd_counter_2digit #(
  parameter int unsigned DIV = 1,
  parameter int unsigned PW  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_ones,
  input  logic [3:0] load_tens,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tc,
  output logic       load_err
);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  logic [PW-1:0] pre;
  logic          step;
  logic          ones_bad;
  logic          tens_bad;
  logic [3:0]    ones_next;
  logic [3:0]    tens_next;
  logic          wrap;

  // A step happens on the enabled cycle that completes a full prescale period.
  assign step     = en && (pre == PRE_LAST);
  assign ones_bad = (load_ones > 4'd9);
  assign tens_bad = (load_tens > 4'd9);

  // Next digit values for a step; only consumed when step is high.
  always_comb begin
    ones_next = ones;
    tens_next = tens;
    wrap      = 1'b0;
    if (up) begin
      if (ones == 4'd9) begin
        ones_next = 4'd0;
        if (tens == 4'd9) begin
          tens_next = 4'd0;
          wrap      = 1'b1;
        end else begin
          tens_next = tens + 4'd1;
        end
      end else begin
        ones_next = ones + 4'd1;
      end
    end else begin
      if (ones == 4'd0) begin
        ones_next = 4'd9;
        if (tens == 4'd0) begin
          tens_next = 4'd9;
          wrap      = 1'b1;
        end else begin
          tens_next = tens - 4'd1;
        end
      end else begin
        ones_next = ones - 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones     <= 4'd0;
      tens     <= 4'd0;
      pre      <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else if (clr) begin
      ones     <= 4'd0;
      tens     <= 4'd0;
      pre      <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      ones     <= ones_bad ? 4'd0 : load_ones;
      tens     <= tens_bad ? 4'd0 : load_tens;
      pre      <= '0;
      tc       <= 1'b0;
      load_err <= ones_bad || tens_bad;
    end else begin
      tc       <= 1'b0;
      load_err <= 1'b0;
      if (en) begin
        pre <= step ? '0 : pre + PRE_ONE;
      end
      if (step) begin
        ones <= ones_next;
        tens <= tens_next;
        tc   <= wrap;
      end
    end
  end

endmodule
